// File: rtl/in_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : in_debounce_pkg
//  Purpose  : Shared types and constants for the in_debounce input stage.
//  Revision : 1.0 - initial release
// ============================================================================
package in_debounce_pkg;

    // Debounce FSM state encoding (2 bits, legacy-compatible constants)
    typedef logic [1:0] state_t;

    localparam state_t IDLE_LO = 2'b00;
    localparam state_t CHK_HI  = 2'b01;
    localparam state_t IDLE_HI = 2'b10;
    localparam state_t CHK_LO  = 2'b11;

    // Default glitch counter width and its saturation value
    localparam int                    GCNT_W_DEF = 8;
    localparam logic [GCNT_W_DEF-1:0] GCNT_SAT   = '1;

endpackage : in_debounce_pkg
`default_nettype wire

// File: rtl/in_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module   : in_debounce_if
//  Purpose  : Raw pin / enable in, conditioned level, strobes and status out.
//  Revision : 1.0 - initial release
// ============================================================================
interface in_debounce_if
    import in_debounce_pkg::*;
#(
    parameter int GCNT_W = GCNT_W_DEF
);
    logic              RAW_IN;
    logic              EN;
    logic              IN;
    logic              RISE;
    logic              FALL;
    logic              BUSY;
    logic [GCNT_W-1:0] GLITCH_CNT;

    // Source side: drives the raw pin and enable, observes the clean outputs
    modport master (
        output RAW_IN, EN,
        input  IN, RISE, FALL, BUSY, GLITCH_CNT
    );

    // Debouncer side
    modport slave (
        input  RAW_IN, EN,
        output IN, RISE, FALL, BUSY, GLITCH_CNT
    );
endinterface : in_debounce_if
`default_nettype wire

// File: rtl/in_debounce_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module   : sync_chain
//  Purpose  : Multi-flop synchroniser with synchronous active-high reset.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic D,
    output logic      Q
);
    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through STAGES flops
    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], D};
        end
    end

    assign Q = chain[STAGES-1];
endmodule : sync_chain
`default_nettype wire

// File: rtl/in_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : in_debounce
//  Purpose  : Synchronise, debounce and edge-detect a raw input pin; counts
//             rejected glitches with a saturating counter.
//  Revision : 1.0 - initial release
// ============================================================================
module in_debounce
    import in_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GCNT_W          = GCNT_W_DEF
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    in_debounce_if.slave     bus
);
    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GCNT_W-1:0] GLITCH_MAX = '1;

    logic              s;
    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              rise_nxt;
    logic              fall_nxt;
    logic              glitch;
    logic              level;
    logic              rise;
    logic              fall;
    logic              busy;
    logic [GCNT_W-1:0] glitch_cnt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (bus.RAW_IN),
        .Q   (s)
    );

    // Next-state: EN low collapses any check back to its idle state without
    // counting a glitch; an abort needs EN high and s back at the old level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        glitch    = 1'b0;
        case (state)
            IDLE_LO: begin
                if (bus.EN && s) begin
                    state_nxt = CHK_HI;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CHK_HI: begin
                if (!bus.EN) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                end else if (!s) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                    glitch    = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            IDLE_HI: begin
                if (bus.EN && !s) begin
                    state_nxt = CHK_LO;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CHK_LO: begin
                if (!bus.EN) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                end else if (s) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                    glitch    = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Register state, outputs and the saturating glitch counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE_LO;
            cnt        <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            busy       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= (state_nxt == CHK_HI) || (state_nxt == CHK_LO);
            if (rise_nxt) begin
                level <= 1'b1;
            end else if (fall_nxt) begin
                level <= 1'b0;
            end
            if (glitch && (glitch_cnt != GLITCH_MAX)) begin
                glitch_cnt <= glitch_cnt + 1'b1;
            end
        end
    end

    assign bus.IN         = level;
    assign bus.RISE       = rise;
    assign bus.FALL       = fall;
    assign bus.BUSY       = busy;
    assign bus.GLITCH_CNT = glitch_cnt;
endmodule : in_debounce
`default_nettype wire

// File: tb/tb_in_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_in_debounce
//  Purpose  : Directed self-checking bench for in_debounce (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_in_debounce;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    in_debounce_if #(.GCNT_W(8)) bus ();

    in_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .GCNT_W          (8)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {IN, RISE, FALL, BUSY}
    function automatic logic [3:0] flags();
        return {bus.IN, bus.RISE, bus.FALL, bus.BUSY};
    endfunction

    // Move RAW_IN to lvl and check edges 1..7 of a clean accepted change
    task automatic clean_edge(input logic lvl);
        logic [3:0] exp;
        bus.RAW_IN = lvl;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp[3] = (e >= 6) ? lvl : ~lvl;
            exp[2] = lvl && (e == 6);
            exp[1] = !lvl && (e == 6);
            exp[0] = (e >= 3) && (e <= 5);
            chk($sformatf("%s_edge%0d", lvl ? "rise" : "fall", e), 32'(flags()), 32'(exp));
        end
    endtask

    initial begin
        logic [3:0] exp;
        bus.RAW_IN = 1'b0;
        bus.EN     = 1'b1;

        // Reset and idle
        rst = 1'b1;
        repeat (3) tick();
        chk("reset", 32'({flags(), bus.GLITCH_CNT}), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_%0d", i), 32'({flags(), bus.GLITCH_CNT}), 32'h0);
        end

        // Clean rise then clean fall
        clean_edge(1'b1);
        clean_edge(1'b0);

        // EN dropped in the 2nd CHK_HI cycle, then re-asserted
        bus.RAW_IN = 1'b1;
        tick();
        tick();
        tick();
        chk("en_chk1", 32'(flags()), 32'h1);
        tick();
        chk("en_chk2", 32'(flags()), 32'h1);
        bus.EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("en_off_%0d", i), 32'(flags()), 32'h0);
        end
        bus.EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("en_reon_%0d", i), 32'(flags()), 32'h1);
        end
        tick();
        chk("en_accept", 32'(flags()), 32'hC);
        chk("en_no_glitch", 32'(bus.GLITCH_CNT), 32'h0);
        tick();
        chk("en_rise_clear", 32'(flags()), 32'h8);

        // Falling raw level while EN low: hold, no strobes
        bus.RAW_IN = 1'b0;
        bus.EN     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("en_hold_%0d", i), 32'(flags()), 32'h8);
        end
        bus.EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fall_reon_%0d", i), 32'(flags()), 32'h9);
        end
        tick();
        chk("fall_reon_accept", 32'(flags()), 32'h2);
        chk("fall_reon_gcnt", 32'(bus.GLITCH_CNT), 32'h0);

        // Single 3-cycle glitch
        for (int e = 1; e <= 11; e++) begin
            bus.RAW_IN = (e <= 3);
            tick();
            exp = {3'b000, (e >= 3) && (e <= 5)};
            chk($sformatf("glitch_edge%0d", e), 32'(flags()), 32'(exp));
        end
        bus.RAW_IN = 1'b0;
        chk("glitch_cnt1", 32'(bus.GLITCH_CNT), 32'h1);

        // 299 more glitches: counter saturates at 255
        for (int g = 0; g < 299; g++) begin
            bus.RAW_IN = 1'b1;
            repeat (3) tick();
            bus.RAW_IN = 1'b0;
            repeat (5) tick();
        end
        chk("glitch_in_low", 32'({bus.IN, bus.RISE}), 32'h0);
        chk("glitch_sat", 32'(bus.GLITCH_CNT), 32'hFF);

        // Reset in CHK_HI with cnt=2
        bus.RAW_IN = 1'b1;
        repeat (4) tick();
        chk("rst_mid_busy", 32'(flags()), 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_mid", 32'({flags(), bus.GLITCH_CNT}), 32'h0);
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = {(e == 6), (e == 6), 1'b0, (e >= 3) && (e <= 5)};
            chk($sformatf("post_rst_edge%0d", e), 32'(flags()), 32'(exp));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_in_debounce
`default_nettype wire

// File: doc/in_debounce.md
Name: in_debounce

Overview:
Input conditioning stage that sits directly upstream of TOP and drives TOP's IN port.
- Synchronises an asynchronous raw pin into the CLK domain.
- Filters glitches with a consecutive-sample debounce state machine.
- Emits a clean level plus single-cycle rise/fall strobes.
- Counts rejected glitches for status readback.

Parameters:
SYNC_STAGES, 2, number of flops in the synchroniser chain (legal range >= 2).
DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to accept a level change (legal range >= 2).
CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width (derived; not overridden).
GCNT_W, 8, glitch counter width.

Ports:
CLK  input  1  single system clock, rising edge.
RST  input  1  synchronous, active-high reset.
RAW_IN  input  1  asynchronous raw input.
EN  input  1  filter enable.
IN  output  1  debounced level, feeds TOP.IN.
RISE  output  1  one-cycle strobe on accepted 0->1.
FALL  output  1  one-cycle strobe on accepted 1->0.
BUSY  output  1  high while in a CHK state.
GLITCH_CNT  output  GCNT_W  saturating count of aborted checks.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high. All state changes occur only on rising CLK edges.
- Reset (RST=1 at an edge):
  - sync chain all 0, state IDLE_LO, cnt=0.
  - IN=0, RISE=0, FALL=0, BUSY=0, GLITCH_CNT=0.
  - RST overrides everything, including a check in progress.
- Synchroniser:
  - s = RAW_IN delayed SYNC_STAGES edges.
  - Runs regardless of EN.
- FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO.
- IDLE_LO: s=1 -> CHK_HI, cnt=1. Otherwise stay.
- CHK_HI:
  - s=0 -> IDLE_LO, cnt=0, GLITCH_CNT+1.
  - else cnt==DEBOUNCE_CYCLES-1 -> IDLE_HI, IN=1, RISE=1.
  - else cnt+1.
- IDLE_HI / CHK_LO: mirror of the above with s inverted; accepting the change clears IN and pulses FALL.
- RISE/FALL:
  - Registered, high exactly one cycle, coincident with the IN change.
  - Never both high in the same cycle.
- BUSY: registered, =1 exactly when state is CHK_HI or CHK_LO.
- Latency: counting the edge that first samples a new RAW_IN level as edge 1, IN changes at edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 6), provided RAW_IN stays stable throughout.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES synchronised samples never changes IN.
- EN=0:
  - Stable states hold.
  - A CHK state returns to its originating IDLE state with cnt=0; this does not count as a glitch.
  - No strobes are produced.
  - The synchroniser continues running.
- EN re-assert: evaluation restarts from the current IDLE state using the current s; there is no memory of the earlier partial count.
- GLITCH_CNT saturates at all-ones and does not wrap. Cleared only by RST.
- Simultaneous events:
  - Abort and accept cannot coincide, since accept requires s equal to the target level.
  - EN=0 in the same cycle cnt reaches the limit: EN wins, no change, no strobe.

Decomposition:
- Package in_debounce_pkg:
  - state typedef (IDLE_LO, CHK_HI, IDLE_HI, CHK_LO, 2-bit encoding).
  - localparam for GCNT saturation value.
- Sub-module sync_chain:
  - parameter STAGES, ports CLK, RST, D, Q.
  - Synchronous-reset flop chain, reusable elsewhere in the codebase.

Test Plan:
- Reset/idle: RST high 3 cycles, then RAW_IN=0 for 10 cycles -> IN=0, RISE=FALL=BUSY=0, GLITCH_CNT=0 throughout.
- Clean rise (defaults): RAW_IN 0->1 sampled at edge 1 and held -> BUSY high edges 3-5, IN=1 and RISE=1 at edge 6, RISE=0 at edge 7.
- Glitch: RAW_IN high for exactly 3 cycles, then low -> IN stays 0, no RISE, GLITCH_CNT=1; repeat 300 times -> GLITCH_CNT=255 (saturated).
- Clean fall from IN=1: RAW_IN 1->0 held -> FALL=1 and IN=0 at edge 6 after first low sample; RISE stays 0.
- EN interaction: start a rise, drop EN at the 2nd CHK_HI cycle for 5 cycles while RAW_IN stays 1 -> BUSY=0, IN=0, GLITCH_CNT unchanged. Re-assert EN -> IN=1 exactly DEBOUNCE_CYCLES edges after re-assertion.
- Reset mid-check: assert RST during CHK_HI with cnt=2 -> next edge IN=0, BUSY=0, cnt=0. After RST is released, RAW_IN held high gives IN=1 at edge SYNC_STAGES+DEBOUNCE_CYCLES.
